load_store_unit: RTL and testbench

Memory-access stage of the core pipeline, sitting directly upstream of the byte-addressed data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the memory's read port and write port 0. It also performs RISC-V sub-word handling: sign or zero extension for loads, and read-modify-write for SB/SH. Results return to writeback as a single-cycle response pulse.

---
 rtl/load_store_unit.sv | 104 ++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage; RISC-V sub-word load extension and SB/SH read-modify-write
// over a single-outstanding valid/ready request port.
module load_store_unit #(
    parameter int READ_WAIT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic [31:0] o_r_mem_addr,
    input  logic [31:0] i_r_mem_data,
    output logic [31:0] o_w_mem_addr,
    output logic [31:0] o_w_mem_data,
    output logic        o_w_mem_en
);
    localparam int CW = READ_WAIT > 1 ? $clog2(READ_WAIT) : 1;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, err_q, err_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d, data_q, data_d;
    logic [31:0]   ext, merge;
    logic          accept, legal, bad;
    assign o_req_ready = state_q == IDLE;
    assign accept      = i_req_valid && o_req_ready;
    assign legal       = i_req_we ? i_req_funct3 <= 3'd2 : (i_req_funct3 != 3'd3 && i_req_funct3 <= 3'd5);
    // Address 0 doubles as the "no read" code, so only SW may target it.
    assign bad         = !legal || (i_req_addr == '0 && !(i_req_we && i_req_funct3 == 3'd2));
    assign ext   = f3_q[1] ? i_r_mem_data :
                   f3_q[0] ? {{16{~f3_q[2] & i_r_mem_data[31]}}, i_r_mem_data[31:16]} :
                             {{24{~f3_q[2] & i_r_mem_data[31]}}, i_r_mem_data[31:24]};
    // data_q holds store data until the read phase replaces it with the merged word.
    assign merge = f3_q[0] ? {data_q[15:0], i_r_mem_data[15:0]} : {data_q[7:0], i_r_mem_data[23:0]};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = i_req_we;
                f3_d    = i_req_funct3;
                addr_d  = i_req_addr;
                data_d  = i_req_wdata;
                err_d   = bad;
                cnt_d   = '0;
                state_d = bad ? RESP : (i_req_we && i_req_funct3 == 3'd2) ? WRITE : READ;
            end
            READ: if (cnt_q == CW'(READ_WAIT - 1)) begin
                data_d  = we_q ? merge : ext;
                cnt_d   = '0;
                state_d = we_q ? WRITE : RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_error <= 1'b0;
            o_resp_rdata <= '0;
            o_w_mem_en   <= 1'b0;
            o_w_mem_addr <= '0;
            o_w_mem_data <= '0;
            o_r_mem_addr <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            o_resp_valid <= state_d == RESP;
            o_resp_error <= state_d == RESP && err_d;
            o_resp_rdata <= (state_d == RESP && !err_d && !we_d) ? data_d : '0;
            o_w_mem_en   <= state_d == WRITE;
            o_w_mem_addr <= state_d == WRITE ? addr_d : '0;
            o_w_mem_data <= state_d == WRITE ? data_d : '0;
            o_r_mem_addr <= state_d == READ ? addr_d : '0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, reset corners, back-to-back handshake and random
// transactions against a byte-array memory and a transaction-level reference model.
module tb_load_store_unit;
    localparam int RW = 2;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_req_valid = 1'b0, i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0, i_r_mem_data;
    logic        o_req_ready, o_resp_valid, o_resp_error, o_w_mem_en;
    logic [31:0] o_resp_rdata, o_r_mem_addr, o_w_mem_addr, o_w_mem_data;
    logic [7:0]  mem [0:1023];
    int          checks = 0, errors = 0, wr_cnt = 0, cyc = 0;
    bit          bb_on = 0;
    logic [31:0] bb_q[$];
    int          bb_t[$];

    load_store_unit #(.READ_WAIT(RW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
        .o_resp_error(o_resp_error), .o_r_mem_addr(o_r_mem_addr), .i_r_mem_data(i_r_mem_data),
        .o_w_mem_addr(o_w_mem_addr), .o_w_mem_data(o_w_mem_data), .o_w_mem_en(o_w_mem_en)
    );

    always #5 i_clk = ~i_clk;

    assign i_r_mem_data = o_r_mem_addr == 0 ? 32'h0 :
        {mem[10'(o_r_mem_addr)], mem[10'(o_r_mem_addr + 1)], mem[10'(o_r_mem_addr + 2)], mem[10'(o_r_mem_addr + 3)]};

    always @(posedge i_clk) begin
        cyc++;
        if (o_w_mem_en) begin
            for (int i = 0; i < 4; i++) mem[10'(o_w_mem_addr + i)] = o_w_mem_data[31 - 8 * i -: 8];
            wr_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: a request reads a big-endian word, keeps the top 1/2/4 bytes for loads
    // (signed or not), or overwrites them with the low bytes of wdata for stores.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, w,
                                  output logic err, output logic [31:0] rd, output int lat,
                                  output bit wr, output logic [31:0] wd);
        longint old, v, n;
        old = {mem[10'(a)], mem[10'(a + 1)], mem[10'(a + 2)], mem[10'(a + 3)]};
        n   = 8 * (1 << f3[1:0]);
        err = (we ? f3 > 2 : (f3 == 3 || f3 > 5)) || (a == 0 && !(we && f3 == 2));
        rd = 0; wr = 0; wd = 0; lat = 1;
        if (!err && !we) begin
            v = old >> (32 - n);
            if (!f3[2] && v >= (64'd1 << (n - 1))) v -= 64'd1 << n;
            rd  = 32'(v);
            lat = RW + 1;
        end else if (!err) begin
            wr  = 1;
            lat = n == 32 ? 2 : RW + 2;
            wd  = 32'((longint'(w) << (32 - n)) | (old & ((64'd1 << (32 - n)) - 1)));
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, w,
                          input logic [31:0] x_rd, input logic x_err, input string nm);
        logic m_err, g_err;
        logic [31:0] m_rd, m_wd, g_rd, g_wa, g_wd;
        int lat, w0, resp_at, wr_at, nresp, nrd, bad_rd, bad_idle, bad_rdy;
        bit wr;
        model(we, f3, a, w, m_err, m_rd, lat, wr, m_wd);
        w0 = wr_cnt; resp_at = 0; wr_at = 0; nresp = 0; nrd = 0; bad_rd = 0; bad_idle = 0; bad_rdy = 0;
        g_rd = 'x; g_err = 1'bx; g_wa = 'x; g_wd = 'x;
        @(negedge i_clk);
        i_req_valid = 1; i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = w;
        @(posedge i_clk);
        #1;
        i_req_valid = 0; i_req_we = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_addr = $urandom; i_req_wdata = $urandom;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            if (o_r_mem_addr != 0) begin
                nrd++;
                if (o_r_mem_addr != a) bad_rd++;
            end
            if (o_w_mem_en) begin
                wr_at = k; g_wa = o_w_mem_addr; g_wd = o_w_mem_data;
            end
            if (o_resp_valid) begin
                nresp++;
                if (resp_at == 0) begin
                    resp_at = k; g_rd = o_resp_rdata; g_err = o_resp_error;
                end
            end else if (o_resp_rdata != 0 || o_resp_error) bad_idle++;
            if (o_req_ready && (resp_at == 0 || resp_at == k)) bad_rdy++;
        end
        chk({nm, "_latency"}, resp_at, lat);
        chk({nm, "_resp_count"}, nresp, 1);
        chk({nm, "_rdata"}, g_rd, x_rd);
        chk({nm, "_error"}, {31'b0, g_err}, {31'b0, x_err});
        chk({nm, "_read_cycles"}, nrd, (!m_err && !(we && f3 == 2)) ? RW : 0);
        chk({nm, "_read_addr_bad"}, bad_rd, 0);
        chk({nm, "_write_count"}, wr_cnt - w0, wr ? 1 : 0);
        if (wr) begin
            chk({nm, "_write_cycle"}, wr_at, lat - 1);
            chk({nm, "_write_addr"}, g_wa, a);
            chk({nm, "_write_data"}, g_wd, m_wd);
        end
        chk({nm, "_idle_resp_nonzero"}, bad_idle, 0);
        chk({nm, "_ready_while_busy"}, bad_rdy, 0);
    endtask

    always @(negedge i_clk) begin
        if (bb_on && o_resp_valid) begin
            bb_t.push_back(cyc);
            if (bb_q.size() == 0) chk("bb_extra_resp", o_resp_rdata, 32'hx);
            else chk("bb_rdata", o_resp_rdata, bb_q.pop_front());
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd;
        logic        err;
        string       name;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nw, nr, w0;
        logic m_err;
        logic [31:0] m_rd, m_wd, ra;
        int lat;
        bit wr;
        logic [2:0] bb_f3[3];
        logic [31:0] bb_a[3];
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        // Reset with a request presented: it must be ignored.
        i_req_valid = 1; i_req_we = 1; i_req_funct3 = 3'd2; i_req_addr = 32'h40; i_req_wdata = 32'h11111111;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ctrl", {29'b0, o_resp_valid, o_resp_error, o_w_mem_en}, 0);
        chk("rst_rdata", o_resp_rdata, 0);
        chk("rst_waddr", o_w_mem_addr, 0);
        chk("rst_wdata", o_w_mem_data, 0);
        chk("rst_raddr", o_r_mem_addr, 0);
        chk("rst_ready", {31'b0, o_req_ready}, 1);
        i_rst_n = 1; i_req_valid = 0;
        repeat (3) @(negedge i_clk);
        chk("post_rst_ready", {31'b0, o_req_ready}, 1);
        chk("post_rst_writes", wr_cnt, 0);

        tbl.push_back('{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw"});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw"});
        tbl.push_back('{0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFDE, 0, "lb"});
        tbl.push_back('{0, 3'd4, 32'h10, 32'h0, 32'h000000DE, 0, "lbu"});
        tbl.push_back('{0, 3'd1, 32'h10, 32'h0, 32'hFFFFDEAD, 0, "lh"});
        tbl.push_back('{0, 3'd5, 32'h10, 32'h0, 32'h0000DEAD, 0, "lhu"});
        tbl.push_back('{1, 3'd0, 32'h10, 32'h00000012, 32'h0, 0, "sb"});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'h12ADBEEF, 0, "lw_after_sb"});
        tbl.push_back('{1, 3'd1, 32'h10, 32'hFFFF5678, 32'h0, 0, "sh"});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'h5678BEEF, 0, "lw_after_sh"});
        tbl.push_back('{0, 3'd3, 32'h10, 32'h0, 32'h0, 1, "load_f3_011"});
        tbl.push_back('{0, 3'd2, 32'h0, 32'h0, 32'h0, 1, "lw_addr0"});
        tbl.push_back('{1, 3'd2, 32'h0, 32'hCAFEF00D, 32'h0, 0, "sw_addr0"});
        tbl.push_back('{1, 3'd3, 32'h10, 32'h0, 32'h0, 1, "store_f3_011"});
        tbl.push_back('{1, 3'd0, 32'h0, 32'h0, 32'h0, 1, "sb_addr0"});
        tbl.push_back('{0, 3'd2, 32'h11, 32'h0, 32'h78BEEF00, 0, "lw_unaligned"});
        tbl.push_back('{0, 3'd1, 32'h12, 32'h0, 32'hFFFFBEEF, 0, "lh_unaligned"});
        foreach (tbl[i]) do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, tbl[i].name);

        // Reset lands on the edge that would enter WRITE for an SB.
        w0 = wr_cnt; nw = 0; nr = 0;
        @(negedge i_clk);
        i_req_valid = 1; i_req_we = 1; i_req_funct3 = 3'd0; i_req_addr = 32'h20; i_req_wdata = 32'h55;
        @(posedge i_clk);
        #1 i_req_valid = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rstw_in_read", o_r_mem_addr, 32'h20);
        i_rst_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            if (o_w_mem_en) nw++;
            if (o_resp_valid) nr++;
            i_rst_n = 1;
        end
        chk("rstw_strobes", nw, 0);
        chk("rstw_resps", nr, 0);
        chk("rstw_mem_writes", wr_cnt - w0, 0);
        chk("rstw_ready", {31'b0, o_req_ready}, 1);

        // Back-to-back loads with i_req_valid held high throughout.
        bb_f3 = '{3'd2, 3'd4, 3'd1};
        bb_a  = '{32'h10, 32'h11, 32'h12};
        bb_on = 1;
        @(negedge i_clk);
        i_req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            int t;
            i_req_we = 0; i_req_funct3 = bb_f3[i]; i_req_addr = bb_a[i];
            t = 0;
            while (!o_req_ready && t < 20) begin
                @(negedge i_clk);
                t++;
            end
            model(0, bb_f3[i], bb_a[i], 0, m_err, m_rd, lat, wr, m_wd);
            bb_q.push_back(m_rd);
            @(posedge i_clk);
            #1;
        end
        i_req_valid = 0;
        repeat (12) @(negedge i_clk);
        bb_on = 0;
        chk("bb_resp_count", bb_t.size(), 3);
        chk("bb_pending", bb_q.size(), 0);
        if (bb_t.size() == 3) begin
            chk("bb_spacing_0", bb_t[1] - bb_t[0], RW + 2);
            chk("bb_spacing_1", bb_t[2] - bb_t[1], RW + 2);
        end

        for (int i = 0; i < 60; i++) begin
            logic we;
            logic [2:0] f3;
            logic [31:0] a, w;
            logic [2:0] lf3[5];
            lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            we = 1'($urandom_range(0, 1));
            f3 = $urandom_range(0, 7) == 0 ? 3'($urandom) : (we ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)]);
            a  = $urandom_range(0, 9) == 0 ? 32'h0 : 32'($urandom_range(1, 1000));
            w  = $urandom;
            model(we, f3, a, w, m_err, ra, lat, wr, m_wd);
            do_req(we, f3, a, w, ra, m_err, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
